// File: rtl/sp_wordgen.sv
// Signal-probability word generator: each lane is a first-order sigma-delta
// accumulator whose carry-out stream has a ones density of sp_reg/2^N.
module sp_wordgen #(
    parameter int unsigned N     = 21,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LW    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [$clog2(WIDTH)-1:0] cfg_lane,
    input  logic [N-1:0]             cfg_sp,
    input  logic                     start,
    input  logic [LW-1:0]            win_len,
    input  logic                     abort,
    output logic                     word_valid,
    input  logic                     word_ready,
    output logic [WIDTH-1:0]         wlord,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned LANE_W = $clog2(WIDTH);
    localparam int unsigned LCW    = LANE_W + 1;
    localparam int unsigned NW     = N + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [N-1:0]    sp_reg [WIDTH];
    logic [N-1:0]    acc    [WIDTH];
    logic [N-1:0]    sum    [WIDTH];
    logic [WIDTH-1:0] carry;
    logic [LW-1:0]   cnt, len;
    logic            load, adv, cfg_we;

    // Per-lane accumulate: the carry is the lane's output bit for this word.
    always_comb begin
        carry = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = '0;
            {carry[i], sum[i]} = NW'(acc[i]) + NW'(sp_reg[i]);
        end
    end

    assign wlord  = word_valid ? carry : '0;
    assign cfg_we = cfg_valid && (state == IDLE) && (LCW'(cfg_lane) < LCW'(WIDTH));

    // Next-state and datapath control; abort wins over a same-cycle handshake.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        adv       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = (win_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (word_ready) begin
                    adv = 1'b1;
                    if (cnt == len - LW'(1)) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Status flags are registered from the next state so they track it exactly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cfg_ready  <= 1'b1;
        end else begin
            word_valid <= (state_nxt == RUN);
            busy       <= (state_nxt != IDLE);
            done       <= (state_nxt == DONE);
            cfg_ready  <= (state_nxt == IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                sp_reg[i] <= '0;
                acc[i]    <= '0;
            end
            cnt <= '0;
            len <= '0;
        end else begin
            if (cfg_we) begin
                sp_reg[cfg_lane] <= cfg_sp;
            end
            if (load) begin
                for (int i = 0; i < WIDTH; i++) begin
                    acc[i] <= '0;
                end
                cnt <= '0;
                len <= win_len;
            end else if (adv) begin
                for (int i = 0; i < WIDTH; i++) begin
                    acc[i] <= sum[i];
                end
                cnt <= cnt + LW'(1);
            end
        end
    end

endmodule

// File: tb/tb_sp_wordgen.sv
// Directed self-checking bench for sp_wordgen with hand-computed lane sequences.
module tb_sp_wordgen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [4:0]  cfg_lane;
    logic [20:0] cfg_sp;
    logic        start;
    logic [15:0] win_len;
    logic        abort;
    logic        word_valid;
    logic        word_ready;
    logic [31:0] wlord;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    // lane3 at sp=3/8: words 1..8 = 0,0,1,0,0,1,0,1 (bit k-1 = word k)
    logic [7:0] seq38 = 8'b1010_0100;

    sp_wordgen dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_lane(cfg_lane), .cfg_sp(cfg_sp), .start(start), .win_len(win_len),
        .abort(abort), .word_valid(word_valid), .word_ready(word_ready),
        .wlord(wlord), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [4:0] lane, input logic [20:0] sp);
        cfg_valid = 1'b1;
        cfg_lane  = lane;
        cfg_sp    = sp;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic start_win(input logic [15:0] len);
        start   = 1'b1;
        win_len = len;
        tick();
        start   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        checks++;
        if (word_valid !== 1'b0) begin errors++; $display("FAIL reset_word_valid got %b want 0", word_valid); end
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_done_busy got %b%b want 00", done, busy); end
        checks++;
        if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready got %b want 1", cfg_ready); end
        checks++;
        if (wlord !== 32'h0) begin errors++; $display("FAIL reset_wlord got %h want 0", wlord); end
    endtask

    task automatic test_half();
        logic [31:0] exp;
        cfg_write(5'd0, 21'h100000);
        start_win(16'd6);
        for (int k = 1; k <= 6; k++) begin
            exp = (k % 2 == 0) ? 32'h1 : 32'h0;
            checks++;
            if (word_valid !== 1'b1 || wlord !== exp) begin
                errors++;
                $display("FAIL half_word%0d got v=%b w=%h want v=1 w=%h", k, word_valid, wlord, exp);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || word_valid !== 1'b0) begin
            errors++;
            $display("FAIL half_done got d=%b b=%b v=%b want 1 1 0", done, busy, word_valid);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL half_idle got d=%b b=%b r=%b want 0 0 1", done, busy, cfg_ready);
        end
    endtask

    task automatic test_three_eighths();
        logic [31:0] exp;
        int ones;
        ones = 0;
        cfg_write(5'd0, 21'h0);
        cfg_write(5'd3, 21'h0C0000);
        start_win(16'd8);
        for (int k = 1; k <= 8; k++) begin
            exp = {28'h0, seq38[k-1], 3'b000};
            ones += int'(wlord[3]);
            checks++;
            if (word_valid !== 1'b1 || wlord !== exp) begin
                errors++;
                $display("FAIL sp38_word%0d got v=%b w=%h want v=1 w=%h", k, word_valid, wlord, exp);
            end
            tick();
        end
        checks++;
        if (ones != 3) begin errors++; $display("FAIL sp38_ones got %0d want 3", ones); end
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL sp38_done got %b want 1", done); end
        tick();
    endtask

    task automatic test_back_to_back_stall();
        logic [31:0] exp;
        start_win(16'd8);
        for (int k = 1; k <= 8; k++) begin
            exp = {28'h0, seq38[k-1], 3'b000};
            if (k == 2 || k == 5) begin
                word_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    checks++;
                    if (word_valid !== 1'b1 || wlord !== exp || done !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_word%0d_cyc%0d got v=%b w=%h d=%b want v=1 w=%h d=0",
                                 k, s, word_valid, wlord, done, exp);
                    end
                end
                word_ready = 1'b1;
            end
            checks++;
            if (word_valid !== 1'b1 || wlord !== exp) begin
                errors++;
                $display("FAIL stall_word%0d got v=%b w=%h want v=1 w=%h", k, word_valid, wlord, exp);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || word_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_done got d=%b v=%b want 1 0", done, word_valid);
        end
        tick();
    endtask

    task automatic test_cfg_busy();
        logic [31:0] exp;
        start_win(16'd8);
        checks++;
        if (cfg_ready !== 1'b0) begin errors++; $display("FAIL busy_cfg_ready got %b want 0", cfg_ready); end
        cfg_valid = 1'b1;
        cfg_lane  = 5'd3;
        cfg_sp    = 21'h1FFFFF;
        for (int k = 1; k <= 8; k++) begin
            exp = {28'h0, seq38[k-1], 3'b000};
            checks++;
            if (wlord !== exp || cfg_ready !== 1'b0) begin
                errors++;
                $display("FAIL busy_word%0d got w=%h r=%b want w=%h r=0", k, wlord, cfg_ready, exp);
            end
            tick();
        end
        cfg_valid = 1'b0;
        tick();
        start_win(16'd8);
        for (int k = 1; k <= 8; k++) begin
            exp = {28'h0, seq38[k-1], 3'b000};
            checks++;
            if (wlord !== exp) begin
                errors++;
                $display("FAIL rerun_word%0d got %h want %h", k, wlord, exp);
            end
            tick();
        end
        tick();
    endtask

    task automatic test_abort();
        logic [31:0] exp;
        start_win(16'd8);
        for (int k = 1; k <= 3; k++) begin
            // a start during RUN must not restart the window
            start   = (k == 2);
            win_len = 16'd2;
            exp = {28'h0, seq38[k-1], 3'b000};
            checks++;
            if (wlord !== exp) begin
                errors++;
                $display("FAIL abort_pre_word%0d got %h want %h", k, wlord, exp);
            end
            tick();
        end
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (word_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b1 || wlord !== 32'h0) begin
            errors++;
            $display("FAIL abort_idle got v=%b b=%b d=%b r=%b w=%h want 0 0 0 1 0",
                     word_valid, busy, done, cfg_ready, wlord);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done got d=%b b=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_zero_len();
        start_win(16'd0);
        checks++;
        if (word_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL zero_len got v=%b d=%b b=%b want 0 1 1", word_valid, done, busy);
        end
        tick();
        checks++;
        if (word_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_idle got v=%b d=%b b=%b want 0 0 0", word_valid, done, busy);
        end
    endtask

    task automatic test_reset_mid_run();
        start_win(16'd8);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (word_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1 || wlord !== 32'h0) begin
            errors++;
            $display("FAIL midrst got v=%b d=%b b=%b r=%b w=%h want 0 0 0 1 0",
                     word_valid, done, busy, cfg_ready, wlord);
        end
        start_win(16'd8);
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if (word_valid !== 1'b1 || wlord !== 32'h0) begin
                errors++;
                $display("FAIL midrst_cleared_word%0d got v=%b w=%h want v=1 w=0", k, word_valid, wlord);
            end
            tick();
        end
        tick();
    endtask

    initial begin
        rst_n      = 1'b0;
        cfg_valid  = 1'b0;
        cfg_lane   = 5'd0;
        cfg_sp     = 21'h0;
        start      = 1'b0;
        win_len    = 16'd0;
        abort      = 1'b0;
        word_ready = 1'b1;
        #1;
        test_reset();
        test_half();
        test_three_eighths();
        test_back_to_back_stall();
        test_cfg_busy();
        test_abort();
        test_zero_len();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
